// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between two requesters, with in-order response routing
module mem_port_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req0_do_read,
    input  logic          req0_do_write,
    input  logic [TW-1:0] req0_user_tag,
    output logic          rsp0_ready,
    output logic          rsp0_valid,
    output logic [AW-1:0] rsp0_addr,
    output logic [DW-1:0] rsp0_data,
    output logic [TW-1:0] rsp0_user_tag,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          req1_do_read,
    input  logic          req1_do_write,
    input  logic [TW-1:0] req1_user_tag,
    output logic          rsp1_ready,
    output logic          rsp1_valid,
    output logic [AW-1:0] rsp1_addr,
    output logic [DW-1:0] rsp1_data,
    output logic [TW-1:0] rsp1_user_tag,
    output logic          mem_req_valid,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_data,
    output logic          mem_req_do_read,
    output logic          mem_req_do_write,
    output logic [TW-1:0] mem_req_user_tag,
    input  logic          mem_rsp_ready,
    input  logic          mem_rsp_valid,
    input  logic [AW-1:0] mem_rsp_addr,
    input  logic [DW-1:0] mem_rsp_data,
    input  logic [TW-1:0] mem_rsp_user_tag,
    output logic          err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] owner;
    logic [PW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             last;
    logic             can_acc, pick1, push, pop, head;
    logic [AW-1:0]    rsp_addr;
    logic [DW-1:0]    rsp_data;
    logic [TW-1:0]    rsp_tag;

    assign rsp0_addr     = rsp_addr;
    assign rsp0_data     = rsp_data;
    assign rsp0_user_tag = rsp_tag;
    assign rsp1_addr     = rsp_addr;
    assign rsp1_data     = rsp_data;
    assign rsp1_user_tag = rsp_tag;

    // grant decision: full is judged on occupancy before any same-cycle pop
    always_comb begin
        can_acc    = (!mem_req_valid || mem_rsp_ready) && count != CW'(DEPTH) && !reset;
        pick1      = (req0_valid && req1_valid) ? !last : req1_valid;
        rsp0_ready = can_acc && req0_valid && !pick1;
        rsp1_ready = can_acc && req1_valid && pick1;
        push       = rsp0_ready || rsp1_ready;
        pop        = mem_rsp_valid && count != '0;
        head       = owner[rptr];
    end

    // ownership FIFO, occupancy, last-grant pointer and orphan-response flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            last  <= 1'b1;
            err   <= 1'b0;
        end else begin
            if (push) begin
                owner[wptr] <= rsp1_ready;
                wptr        <= wptr + PW'(1);
                last        <= rsp1_ready;
            end
            if (pop) rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            err   <= err || (mem_rsp_valid && count == '0);
        end
    end

    // downstream request register, reloaded or cleared whenever the slot frees
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid    <= 1'b0;
            mem_req_do_read  <= 1'b0;
            mem_req_do_write <= 1'b0;
        end else if (!mem_req_valid || mem_rsp_ready) begin
            mem_req_valid <= push;
            if (push) begin
                mem_req_addr     <= rsp1_ready ? req1_addr : req0_addr;
                mem_req_data     <= rsp1_ready ? req1_data : req0_data;
                mem_req_do_read  <= rsp1_ready ? req1_do_read : req0_do_read;
                mem_req_do_write <= rsp1_ready ? req1_do_write : req0_do_write;
                mem_req_user_tag <= rsp1_ready ? req1_user_tag : req0_user_tag;
            end
        end
    end

    // response routing to the owner at the FIFO head
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= pop && !head;
            rsp1_valid <= pop && head;
            if (pop) begin
                rsp_addr <= mem_rsp_addr;
                rsp_data <= mem_rsp_data;
                rsp_tag  <= mem_rsp_user_tag;
            end
        end
    end
endmodule
